// File: rtl/spi_master12_pkg.sv
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared definitions for the 12-bit mode-0 SPI master:
//                FSM state encoding, default word length, mode-0 levels.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package spi_pkg;

    // Default word length of the link.
    localparam int c_data_w_default = 12;

    // Mode 0: SCK idles low, chip select is active low.
    localparam logic c_sck_idle  = 1'b0;
    localparam logic c_cs_active = 1'b0;

    // Frame sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_t;

endpackage

`default_nettype wire

// File: rtl/spi_master12_if.sv
// ============================================================================
//  Module      : spi_master12_if
//  Description : Controller handshake plus SPI pins of the SPI master.
//                Optional macro SPI_LOOPBACK_EN adds the loopback select.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface spi_master12_if
    import spi_pkg::*;
#(
    parameter int DATA_W = c_data_w_default
);
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic [DATA_W-1:0] rx_data;
    logic              busy;
    logic              done;
    logic              sck;
    logic              cs;
    logic              simo;
    logic              somi;
`ifdef SPI_LOOPBACK_EN
    logic              loopback;
`endif

    // The SPI master itself.
    modport master (
`ifdef SPI_LOOPBACK_EN
        input  loopback,
`endif
        input  start, tx_data, somi,
        output rx_data, busy, done, sck, cs, simo
    );

    // The far side: local controller plus the remote SPI slave.
    modport slave (
`ifdef SPI_LOOPBACK_EN
        output loopback,
`endif
        output start, tx_data, somi,
        input  rx_data, busy, done, sck, cs, simo
    );

endinterface

`default_nettype wire

// File: rtl/spi_master12_clk_div.sv
// ============================================================================
//  Module      : spi_clk_div
//  Description : Emits a one-cycle tick every CLK_DIV cycles while enabled;
//                the count restarts from zero whenever the enable drops.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic en,
    output logic      tick
);

    localparam int c_cnt_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(CLK_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Free-running divide counter, held at zero while disabled.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_cnt <= '0;
        end else if (r_cnt == c_cnt_max) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = en && (r_cnt == c_cnt_max);

endmodule

`default_nettype wire

// File: rtl/spi_master12.sv
// ============================================================================
//  Module      : spi_master12
//  Description : Mode-0 SPI master. Sends one DATA_W-bit word MSB first on
//                SIMO while collecting one word from SOMI, framed by CS.
//                Optional macro SPI_LOOPBACK_EN: LOOPBACK=1 feeds the
//                receive path from the internal SIMO value.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_master12
    import spi_pkg::*;
#(
    parameter int DATA_W  = c_data_w_default,
    parameter int CLK_DIV = 2
) (
    input  wire logic      clk,
    input  wire logic      rst,
    spi_master12_if.master bus
);

    localparam int c_half_w = $clog2(2 * DATA_W);
    localparam logic [c_half_w-1:0] c_half_last = c_half_w'(2 * DATA_W - 1);

    spi_state_t r_state, w_state_nxt;

    // Transmit shifter holds only the bits still to be sent after the MSB.
    logic [DATA_W-2:0]   r_tx_sr,   w_tx_sr_nxt;
    logic [DATA_W-1:0]   r_rx_sr,   w_rx_sr_nxt;
    logic [DATA_W-1:0]   r_rx_data, w_rx_data_nxt;
    logic [c_half_w-1:0] r_half,    w_half_nxt;
    logic                r_sck,     w_sck_nxt;
    logic                r_cs,      w_cs_nxt;
    logic                r_simo,    w_simo_nxt;
    logic                r_busy,    w_busy_nxt;
    logic                r_done,    w_done_nxt;
    logic                w_tick;
    logic                w_rx_bit;

    // Divider runs for the whole frame so every phase lasts CLK_DIV cycles.
    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk  (clk),
        .rst  (rst),
        .en   (r_state != ST_IDLE),
        .tick (w_tick)
    );

`ifdef SPI_LOOPBACK_EN
    logic r_lb, w_lb_nxt;

    // Loopback select is frozen for the frame at acceptance time.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lb <= 1'b0;
        end else begin
            r_lb <= w_lb_nxt;
        end
    end

    assign w_lb_nxt = (r_state == ST_IDLE && bus.start) ? bus.loopback : r_lb;
    assign w_rx_bit = r_lb ? r_simo : bus.somi;
`else
    assign w_rx_bit = bus.somi;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath decode for the frame sequencer.
    always_comb begin
        w_state_nxt   = r_state;
        w_tx_sr_nxt   = r_tx_sr;
        w_rx_sr_nxt   = r_rx_sr;
        w_rx_data_nxt = r_rx_data;
        w_half_nxt    = r_half;
        w_sck_nxt     = r_sck;
        w_cs_nxt      = r_cs;
        w_simo_nxt    = r_simo;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_tx_sr_nxt = bus.tx_data[DATA_W-2:0];
                    w_simo_nxt  = bus.tx_data[DATA_W-1];
                    w_rx_sr_nxt = '0;
                    w_half_nxt  = '0;
                    w_cs_nxt    = c_cs_active;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (w_tick) begin
                    w_state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                if (w_tick) begin
                    w_sck_nxt  = ~r_sck;
                    w_half_nxt = r_half + 1'b1;
                    if (r_sck == c_sck_idle) begin
                        // Rising edge: capture the slave's bit.
                        w_rx_sr_nxt = {r_rx_sr[DATA_W-2:0], w_rx_bit};
                    end else if (r_half == c_half_last) begin
                        // Final falling edge: SIMO keeps the LSB into HOLD.
                        w_half_nxt  = '0;
                        w_state_nxt = ST_HOLD;
                    end else begin
                        // Falling edge: present the next bit.
                        w_simo_nxt  = r_tx_sr[DATA_W-2];
                        w_tx_sr_nxt = r_tx_sr << 1;
                    end
                end
            end
            ST_HOLD: begin
                if (w_tick) begin
                    w_cs_nxt      = ~c_cs_active;
                    w_simo_nxt    = 1'b0;
                    w_rx_data_nxt = r_rx_sr;
                    w_done_nxt    = 1'b1;
                    w_state_nxt   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_tick) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath and pin registers; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_sr   <= '0;
            r_rx_sr   <= '0;
            r_rx_data <= '0;
            r_half    <= '0;
            r_sck     <= c_sck_idle;
            r_cs      <= ~c_cs_active;
            r_simo    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_tx_sr   <= w_tx_sr_nxt;
            r_rx_sr   <= w_rx_sr_nxt;
            r_rx_data <= w_rx_data_nxt;
            r_half    <= w_half_nxt;
            r_sck     <= w_sck_nxt;
            r_cs      <= w_cs_nxt;
            r_simo    <= w_simo_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign bus.rx_data = r_rx_data;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.sck     = r_sck;
    assign bus.cs      = r_cs;
    assign bus.simo    = r_simo;

endmodule

`default_nettype wire

// File: tb/tb_spi_master12.sv
// ============================================================================
//  Module      : tb_spi_master12
//  Description : Directed self-checking bench for spi_master12 (CLK_DIV=2)
//                with a behavioural mode-0 slave.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_master12;

    localparam int DW = 12;
    localparam int CD = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spi_master12_if #(.DATA_W(DW)) bus ();

    spi_master12 #(
        .DATA_W  (DW),
        .CLK_DIV (CD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural slave: MSB ready when CS falls, next bit on each SCK fall.
    logic [DW-1:0] slave_word = '0;
    logic          somi_zero  = 1'b0;
    int            slave_idx  = DW - 1;

    assign bus.somi = somi_zero ? 1'b0 : slave_word[slave_idx];

    always @(posedge bus.cs or negedge bus.sck) begin
        if (bus.cs === 1'b1) slave_idx = DW - 1;
        else if (slave_idx > 0) slave_idx = slave_idx - 1;
    end

    // SIMO captured at every SCK rising edge of the current frame.
    logic [DW-1:0] simo_cap = '0;
    int            rise_cnt = 0;

    always @(posedge bus.sck or negedge bus.cs) begin
        if (bus.sck === 1'b1) begin
            if (bus.cs === 1'b0) begin
                simo_cap = {simo_cap[DW-2:0], bus.simo};
                rise_cnt = rise_cnt + 1;
            end
        end else begin
            simo_cap = '0;
            rise_cnt = 0;
        end
    end

    int done_cnt = 0;
    always @(posedge clk) if (bus.done === 1'b1) done_cnt = done_cnt + 1;

    task automatic test_reset();
        bus.start = 1'b0; bus.tx_data = '0; rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.sck !== 1'b0)   begin errors++; $display("FAIL reset_sck: got %b want 0", bus.sck); end
        checks++; if (bus.cs !== 1'b1)    begin errors++; $display("FAIL reset_cs: got %b want 1", bus.cs); end
        checks++; if (bus.simo !== 1'b0)  begin errors++; $display("FAIL reset_simo: got %b want 0", bus.simo); end
        checks++; if (bus.rx_data !== 12'h000) begin errors++; $display("FAIL reset_rx: got %h want 000", bus.rx_data); end
        checks++; if (bus.busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int  k;
        bit  seen;
        slave_word = 12'hA5C;
        @(negedge clk); bus.start = 1'b1; bus.tx_data = 12'hBBB;
        @(negedge clk); bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", bus.busy); end
        checks++; if (bus.cs !== 1'b0)   begin errors++; $display("FAIL basic_cs: got %b want 0", bus.cs); end
        checks++; if (bus.simo !== 1'b1) begin errors++; $display("FAIL basic_simo_msb: got %b want 1", bus.simo); end
        k = 0; seen = 0;
        while (!seen && k < 200) begin
            @(negedge clk); k++;
            if (bus.done === 1'b1) seen = 1;
        end
        // DONE seen after k edges is sampled high at edge k+1.
        checks++; if (!seen || k + 1 != 53) begin errors++; $display("FAIL basic_latency: got %0d seen=%0d want 53", k + 1, seen); end
        checks++; if (bus.rx_data !== 12'hA5C) begin errors++; $display("FAIL basic_rx: got %h want a5c", bus.rx_data); end
        checks++; if (simo_cap !== 12'hBBB) begin errors++; $display("FAIL basic_simo: got %h want bbb", simo_cap); end
        checks++; if (rise_cnt != 12) begin errors++; $display("FAIL basic_sck_pulses: got %0d want 12", rise_cnt); end
        checks++; if (bus.cs !== 1'b1) begin errors++; $display("FAIL basic_cs_end: got %b want 1", bus.cs); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", bus.done); end
        repeat (4) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b want 0", bus.busy); end
    endtask

    task automatic test_busy_start();
        int  k;
        bit  seen;
        int  d0;
        slave_word = 12'h3C3;
        d0 = done_cnt;
        @(negedge clk); bus.start = 1'b1; bus.tx_data = 12'hBBB;
        @(negedge clk); bus.start = 1'b0;
        repeat (19) @(negedge clk);
        bus.start = 1'b1; bus.tx_data = 12'h123;
        @(negedge clk); bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_start_busy: got %b want 1", bus.busy); end
        k = 0; seen = 0;
        while (!seen && k < 100) begin
            @(negedge clk); k++;
            if (bus.done === 1'b1) seen = 1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL busy_start_done: got none want pulse"); end
        checks++; if (simo_cap !== 12'hBBB) begin errors++; $display("FAIL busy_start_simo: got %h want bbb", simo_cap); end
        checks++; if (bus.rx_data !== 12'h3C3) begin errors++; $display("FAIL busy_start_rx: got %h want 3c3", bus.rx_data); end
        repeat (10) @(negedge clk);
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL busy_start_frames: got %0d want 1", done_cnt - d0); end
        checks++; if (bus.cs !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle: got cs=%b busy=%b want 1/0", bus.cs, bus.busy); end
    endtask

    task automatic test_back_to_back();
        int            n;
        int            ndone;
        int            run;
        int            gap;
        int            d0;
        logic [DW-1:0] cap1, cap2, rx1, rx2;
        slave_word = 12'h0F0;
        d0 = done_cnt; ndone = 0; run = 0; gap = -1;
        cap1 = 'x; cap2 = 'x; rx1 = 'x; rx2 = 'x;
        @(negedge clk); bus.start = 1'b1; bus.tx_data = 12'hFFF;
        @(negedge clk); bus.tx_data = 12'h000;
        n = 0;
        while (ndone < 2 && n < 300) begin
            @(negedge clk); n++;
            if (bus.cs === 1'b1) run++;
            else begin
                if (ndone == 1 && run > 0 && gap < 0) gap = run;
                run = 0;
            end
            if (bus.done === 1'b1) begin
                ndone++;
                if (ndone == 1) begin cap1 = simo_cap; rx1 = bus.rx_data; end
                else begin cap2 = simo_cap; rx2 = bus.rx_data; bus.start = 1'b0; end
            end
        end
        bus.start = 1'b0;
        checks++; if (ndone != 2) begin errors++; $display("FAIL b2b_frames: got %0d want 2", ndone); end
        checks++; if (cap1 !== 12'hFFF) begin errors++; $display("FAIL b2b_simo1: got %h want fff", cap1); end
        checks++; if (cap2 !== 12'h000) begin errors++; $display("FAIL b2b_simo2: got %h want 000", cap2); end
        checks++; if (rx1 !== 12'h0F0 || rx2 !== 12'h0F0) begin errors++; $display("FAIL b2b_rx: got %h/%h want 0f0/0f0", rx1, rx2); end
        checks++; if (gap != 3) begin errors++; $display("FAIL b2b_cs_gap: got %0d want 3", gap); end
        repeat (10) @(negedge clk);
        checks++; if (done_cnt - d0 != 2 || bus.cs !== 1'b1) begin errors++; $display("FAIL b2b_stop: got %0d dones cs=%b want 2 cs=1", done_cnt - d0, bus.cs); end
    endtask

    task automatic test_reset_mid();
        int  k;
        bit  seen;
        int  d0;
        slave_word = 12'h555;
        @(negedge clk); bus.start = 1'b1; bus.tx_data = 12'hABC;
        @(negedge clk); bus.start = 1'b0;
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.cs !== 1'b1 || bus.sck !== 1'b0) begin errors++; $display("FAIL rstmid_pins: got cs=%b sck=%b want 1/0", bus.cs, bus.sck); end
        checks++; if (bus.busy !== 1'b0 || bus.simo !== 1'b0) begin errors++; $display("FAIL rstmid_busy_simo: got %b/%b want 0/0", bus.busy, bus.simo); end
        checks++; if (bus.rx_data !== 12'h000) begin errors++; $display("FAIL rstmid_rx: got %h want 000", bus.rx_data); end
        rst = 1'b0;
        d0 = done_cnt;
        repeat (60) @(negedge clk);
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL rstmid_no_done: got %0d want 0", done_cnt - d0); end
        // Reset and start together: reset must win.
        rst = 1'b1; bus.start = 1'b1; bus.tx_data = 12'hFFF;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.cs !== 1'b1) begin errors++; $display("FAIL rst_start: got busy=%b cs=%b want 0/1", bus.busy, bus.cs); end
        rst = 1'b0; bus.start = 1'b0;
        repeat (3) @(negedge clk);
        slave_word = 12'h35A;
        bus.start = 1'b1; bus.tx_data = 12'h9A6;
        @(negedge clk); bus.start = 1'b0;
        k = 0; seen = 0;
        while (!seen && k < 100) begin
            @(negedge clk); k++;
            if (bus.done === 1'b1) seen = 1;
        end
        checks++; if (!seen || bus.rx_data !== 12'h35A) begin errors++; $display("FAIL rstmid_rx_after: got %h seen=%0d want 35a", bus.rx_data, seen); end
        checks++; if (simo_cap !== 12'h9A6) begin errors++; $display("FAIL rstmid_simo_after: got %h want 9a6", simo_cap); end
        checks++; if (rise_cnt != 12) begin errors++; $display("FAIL rstmid_sck_after: got %0d want 12", rise_cnt); end
        repeat (4) @(negedge clk);
    endtask

`ifdef SPI_LOOPBACK_EN
    task automatic test_loopback();
        int  k;
        bit  seen;
        somi_zero = 1'b1;
        @(negedge clk); bus.start = 1'b1; bus.tx_data = 12'h5A3; bus.loopback = 1'b1;
        @(negedge clk); bus.start = 1'b0; bus.loopback = 1'b0;
        k = 0; seen = 0;
        while (!seen && k < 100) begin
            @(negedge clk); k++;
            if (bus.done === 1'b1) seen = 1;
        end
        checks++; if (!seen || bus.rx_data !== 12'h5A3) begin errors++; $display("FAIL loopback_rx: got %h seen=%0d want 5a3", bus.rx_data, seen); end
        somi_zero = 1'b0;
        repeat (4) @(negedge clk);
    endtask
`endif

    initial begin
        bus.start   = 1'b0;
        bus.tx_data = '0;
`ifdef SPI_LOOPBACK_EN
        bus.loopback = 1'b0;
`endif
        test_reset();
        test_basic();
        test_busy_start();
        test_back_to_back();
        test_reset_mid();
`ifdef SPI_LOOPBACK_EN
        test_loopback();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/spi_master12.md
Name: spi_master12

Overview:
- SPI master: the initiating end of the 12-bit SPI link served by the board's SPI_COM slave.
- Generates SCK and CS from the system clock and shifts one 12-bit word out on SIMO while shifting one 12-bit word in from SOMI.
- Mode 0 framing: SCK idles low, CS is active-low, MSB first, SIMO changes on SCK falling edge, SOMI is sampled on SCK rising edge.
- A local controller issues START/TX_DATA and collects RX_DATA on a one-cycle DONE pulse.

Parameters:
- DATA_W, 12, word length in bits (must be ≥2).
- CLK_DIV, 2, CLK cycles per SCK half-period (must be ≥1).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  request a transfer; sampled only in IDLE.
- TX_DATA  in  DATA_W  word to send; latched in the cycle START is accepted.
- RX_DATA  out  DATA_W  last received word; updated only at DONE.
- BUSY  out  1  high from the cycle after START is accepted through the end of GAP.
- DONE  out  1  one-cycle pulse when RX_DATA becomes valid.
- SCK  out  1  SPI clock.
- CS  out  1  chip select, active low.
- SIMO  out  1  serial data to the slave.
- SOMI  in  1  serial data from the slave; sampled directly, no synchronizer (SCK is derived from CLK).

Behaviour:
- Reset values: SCK=0, CS=1, SIMO=0, RX_DATA=0, BUSY=0, DONE=0; FSM enters IDLE and the divider clears.
- IDLE:
  - START=1 latches TX_DATA into the shift register.
  - Next cycle: CS=0, SIMO=TX_DATA[DATA_W-1], BUSY=1, go to SETUP.
- SETUP: hold for CLK_DIV cycles with SCK=0, then go to XFER.
- XFER: SCK toggles every CLK_DIV cycles, 2*DATA_W half-periods in total.
  - On each 0→1 SCK transition: shift SOMI into the receive register LSB.
  - On each 1→0 SCK transition except the last: drive the next TX bit on SIMO.
  - After the final falling edge: SCK=0, go to HOLD.
- HOLD: CLK_DIV cycles with CS=0 and SCK=0; then CS=1, SIMO=0, RX_DATA=receive register, DONE=1 for one cycle, go to GAP.
- GAP: CS=1 for CLK_DIV cycles with BUSY still 1; then IDLE, BUSY=0.
- Latency:
  - DONE is high exactly (2*DATA_W+2)*CLK_DIV+1 cycles after the CLK edge that samples START.
  - With default parameters this is 53 cycles.
  - Minimum CS-high time between frames is CLK_DIV+1 cycles.
- Boundary conditions:
  - START while BUSY=1: ignored, no queueing.
  - TX_DATA changes during a transfer: no effect on the frame in progress.
  - START held high continuously: back-to-back frames, each separated by the GAP plus the IDLE acceptance cycle.
  - RST during any state: next edge applies the reset values; no DONE pulse; RX_DATA cleared; partial frame discarded.
  - RST and START in the same cycle: RST wins.
- Bit count wraps exactly at DATA_W; no extra SCK edges are ever emitted.

Optional Feature:
- Macro: SPI_LOOPBACK_EN.
- Defined: adds port LOOPBACK (in, 1).
  - LOOPBACK=1: the receive path samples the internal SIMO value instead of SOMI.
  - Pins keep toggling normally.
  - LOOPBACK is sampled only in IDLE when START is accepted and held for the whole frame.
- Undefined: the port is absent and the receive path always uses SOMI.

Decomposition:
- Package spi_pkg holds:
  - FSM state encoding (IDLE, SETUP, XFER, HOLD, GAP);
  - default DATA_W=12;
  - mode-0 constants (SCK idle level 0, CS active level 0).
- One sub-module, spi_clk_div:
  - parameter CLK_DIV; inputs CLK, RST, EN;
  - output TICK, a one-cycle pulse every CLK_DIV cycles while EN=1;
  - counter clears when EN=0.
- The FSM and shift registers stay in spi_master12.

Test Plan:
- Reset: assert RST 3 cycles mid-idle -> SCK=0, CS=1, SIMO=0, RX_DATA=0x000, BUSY=0, DONE=0.
- Basic transfer: TX_DATA=0xBBB, behavioural slave returns 0xA5C -> SIMO at rising edges is 1,0,1,1,1,0,1,1,1,0,1,1; 12 SCK pulses; RX_DATA=0xA5C; DONE 53 cycles after START (CLK_DIV=2).
- START while BUSY: pulse START with TX_DATA=0x123 at cycle 20 of a 0xBBB frame -> exactly one frame sent (0xBBB); second START ignored; BUSY unaffected.
- Back-to-back: START held high with TX_DATA=0xFFF then 0x000 -> two frames; CS high ≥3 cycles between them; two DONE pulses.
- Reset mid-frame: RST at cycle 30 of a frame -> next edge CS=1, SCK=0; no DONE pulse; next START produces a clean full frame.
- Loopback (SPI_LOOPBACK_EN, LOOPBACK=1): TX_DATA=0x5A3, SOMI tied 0 -> RX_DATA=0x5A3.
